pst_id_scoreboard_rf: RTL and testbench
=======================================

Name: pst_id_scoreboard_rf

Overview:
- Parametrised register file for the decode stage with per-register pending-write scoreboard, write-through bypass and stall generation.
- Sits in ID in place of the plain synchronous register file. Gets issue info from the decode/control path and writeback from the WB stage.
- Drives a stall to the pipeline-register enables so dependent instructions wait for producers in flight.

Parameters:
DATA_W, 32, register width
ADDR_W, 5, register index width; depth = 2**ADDR_W
NUM_RD, 2, number of read ports
MAX_PEND, 3, max outstanding writes per register; counter width CNT_W = clog2(MAX_PEND+1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
en  in  1  global enable; 0 freezes all state
flush  in  1  discard all in-flight writes (branch/jump redirect)
issue_valid  in  1  instruction in ID is valid
issue_we  in  1  instruction in ID writes a register
issue_req_w  in  ADDR_W  destination index of ID instruction
rd_need  in  NUM_RD  port i operand actually used
rd_req  in  NUM_RD*ADDR_W  read indices, port i at [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
wb_we  in  1  writeback enable
wb_req  in  ADDR_W  writeback index
wb_data  in  DATA_W  writeback data
stall  out  1  ID must hold; issue not accepted
busy  out  1  any register has pending writes
sb_err  out  1  sticky: writeback to a register with zero pending count
dbg_req  in  ADDR_W  debug read index
dbg_data  out  DATA_W  debug read data, array contents, no bypass

Behaviour:
- Reset, async on rst_n low: all registers = 0, all pending counters = 0, sb_err = 0. Outputs follow: stall = 0, busy = 0, rd_data = 0, dbg_data = 0.
- Register 0 is hardwired zero. Never written, counter never incremented, reads return 0, never causes stall.
- Reads are combinational. If wb_we, wb_req == rd_req[i] and index != 0, port i returns wb_data (bypass). Otherwise it returns array contents. Array updates on the clock edge (visible there 1 cycle later). dbg_data never bypasses.
- hit[i] = rd_need[i] && pend[rd_req[i]] != 0 && !(wb_we && wb_req == rd_req[i] && pend[rd_req[i]] == 1).
- ovf = issue_valid && issue_we && issue_req_w != 0 && pend[issue_req_w] == MAX_PEND.
- stall = issue_valid && (OR of hit[i] || ovf). Purely combinational; also asserted while en = 0 so ID holds.
- accept = issue_valid && issue_we && issue_req_w != 0 && !stall && en && !flush.
- Per-register counter update on clock edge, only when en = 1:
  - flush = 1: all counters -> 0. Overrides accept and wb.
  - accept and wb to the same register in the same cycle: net 0.
  - accept only: +1.
  - wb only: -1, saturating at 0.
- Writeback to a nonzero counter when flush = 0: data written, no error.
- Writeback to a zero counter when flush = 0: data still written, sb_err set. sb_err is cleared only by reset.
- Writeback during flush: data written, no error raised.
- busy = OR over all counters != 0, from registered state.
- en = 0: no array write, no counter change, sb_err held. rd_data is still combinational.
- Reset asserted mid-operation: immediate clear; pending writebacks after reset flag sb_err (expected; pipeline is also reset).

Decomposition:
- Shared package/header: RF_ADDR_W, RF_DATA_W, RF_ZERO_IDX constants, and the clog2 function for CNT_W.
- One sub-module, sb_counter: single-register saturating up/down counter with inc, dec, clr, en and an underflow flag. Instantiate 2**ADDR_W-1 times via generate. Data array and bypass muxes stay in the top module.

Test Plan:
- Reset, then read ports 0/1 at r5/r6 -> rd_data 0, stall 0, busy 0. Write r5 = 0xDEADBEEF via WB -> same-cycle bypass returns 0xDEADBEEF; dbg_data shows it next cycle.
- Issue write r8, next cycle issue read of r8 with rd_need = 1 -> stall = 1 until WB r8 = 0x1234. In the WB cycle stall = 0 and rd_data = 0x1234 (bypass).
- Issue r9 three times (MAX_PEND = 3), then a 4th issue to r9 -> stall = 1 by ovf. One WB r9 -> stall = 0, counter 3 -> 2 -> 3.
- Issue r10 and WB r10 in the same cycle -> counter unchanged, busy unchanged. Read r10 with rd_need = 0 while pending -> no stall.
- Two pending writes to r3 and r4, assert flush -> busy = 0 next cycle. A later WB r3 = 7 -> register holds 7, sb_err = 1 stays set until rst_n low.
- en = 0 with WB r2 = 0x55 and issue r2 -> no change: r2 still 0, counter 0, stall = 1. WB to r0 = 0xFF -> r0 reads 0, no sb_err.

Source files
------------

// File: rtl/pst_id_scoreboard_rf_pkg.sv
// pst_id_scoreboard_rf_pkg: shared constants and clog2 helper for the ID-stage scoreboarded register file
package pst_id_scoreboard_rf_pkg;

    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;
    localparam int RF_ZERO_IDX = 0;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/pst_id_scoreboard_rf_if.sv
// pst_id_scoreboard_rf_if: issue/read/writeback bundle between the pipeline (master) and the register file (slave)
//   issue_valid/issue_we/issue_req_w : decode-stage instruction info
//   rd_need/rd_req/rd_data           : read ports, port i at slice i
//   wb_we/wb_req/wb_data             : writeback from WB
//   stall                            : ID must hold
interface pst_id_scoreboard_rf_if
    import pst_id_scoreboard_rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NUM_RD = 2
);
    logic                     issue_valid;
    logic                     issue_we;
    logic [ADDR_W-1:0]        issue_req_w;
    logic [NUM_RD-1:0]        rd_need;
    logic [NUM_RD*ADDR_W-1:0] rd_req;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     wb_we;
    logic [ADDR_W-1:0]        wb_req;
    logic [DATA_W-1:0]        wb_data;
    logic                     stall;

    modport master (
        output issue_valid, issue_we, issue_req_w, rd_need, rd_req, wb_we, wb_req, wb_data,
        input  rd_data, stall
    );

    modport slave (
        input  issue_valid, issue_we, issue_req_w, rd_need, rd_req, wb_we, wb_req, wb_data,
        output rd_data, stall
    );
endinterface

// File: rtl/pst_id_scoreboard_rf_sb_counter.sv
// sb_counter: per-register pending-write counter, saturating up/down with clear and underflow flag
//   clk, rst_n : clock, async active-low reset
//   en         : hold all state when low
//   clr        : force count to zero (flush)
//   inc, dec   : accepted issue / writeback; both together leave the count unchanged
//   cnt        : current pending count
//   unf        : writeback seen while count is zero
module sb_counter #(
    parameter int MAX_PEND = 3,
    parameter int CNT_W    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             unf
);
    assign unf = dec && cnt == '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (en) begin
            if (clr)
                cnt <= '0;
            else if (inc && !dec && cnt != CNT_W'(MAX_PEND))
                cnt <= cnt + 1'b1;
            else if (dec && !inc && cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end
endmodule

// File: rtl/pst_id_scoreboard_rf.sv
// pst_id_scoreboard_rf: ID-stage register file with pending-write scoreboard, write-through bypass and stall
//   clk, rst_n : clock, async active-low reset
//   en         : global enable, 0 freezes all state
//   flush      : discard all in-flight writes
//   bus        : issue / read / writeback / stall bundle (slave side)
//   busy       : some register has a pending write
//   sb_err     : sticky, writeback to a register with nothing pending
//   dbg_req    : debug index; dbg_data shows raw array contents
module pst_id_scoreboard_rf
    import pst_id_scoreboard_rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int MAX_PEND = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        flush,
    pst_id_scoreboard_rf_if.slave       bus,
    output logic                        busy,
    output logic                        sb_err,
    input  logic [ADDR_W-1:0]           dbg_req,
    output logic [DATA_W-1:0]           dbg_data
);
    localparam int CNT_W = clog2(MAX_PEND + 1);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(RF_ZERO_IDX);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [CNT_W-1:0]  pend [DEPTH];
    logic [DEPTH-1:0]  unf;
    logic [NUM_RD-1:0] hit;
    logic              wb_ok, ovf, accept;

    assign wb_ok  = bus.wb_we && bus.wb_req != ZERO;
    assign ovf    = bus.issue_valid && bus.issue_we && bus.issue_req_w != ZERO &&
                    pend[bus.issue_req_w] == CNT_W'(MAX_PEND);
    // stall also covers en = 0 so ID holds while the file is frozen
    assign bus.stall = bus.issue_valid && (|hit || ovf || !en);
    assign accept = bus.issue_valid && bus.issue_we && bus.issue_req_w != ZERO &&
                    !bus.stall && !flush;

    assign pend[0] = '0;
    assign unf[0]  = 1'b0;

    genvar g;
    generate
        for (g = 1; g < DEPTH; g++) begin : g_cnt
            sb_counter #(.MAX_PEND(MAX_PEND), .CNT_W(CNT_W)) u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (en),
                .clr   (flush),
                .inc   (accept && bus.issue_req_w == ADDR_W'(g)),
                .dec   (wb_ok && bus.wb_req == ADDR_W'(g)),
                .cnt   (pend[g]),
                .unf   (unf[g])
            );
        end
    endgenerate

    genvar i;
    generate
        for (i = 0; i < NUM_RD; i++) begin : g_rd
            logic [ADDR_W-1:0] idx;
            logic              byp;
            assign idx = bus.rd_req[i*ADDR_W +: ADDR_W];
            assign byp = wb_ok && bus.wb_req == idx;
            assign bus.rd_data[i*DATA_W +: DATA_W] = byp ? bus.wb_data : regs[idx];
            // the last outstanding write landing this cycle is satisfied by the bypass
            assign hit[i] = bus.rd_need[i] && pend[idx] != '0 &&
                            !(bus.wb_we && bus.wb_req == idx && pend[idx] == CNT_W'(1));
        end
    endgenerate

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < DEPTH; k++) busy = busy | (pend[k] != '0);
    end

    assign dbg_data = regs[dbg_req];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
        end else if (en && wb_ok) begin
            regs[bus.wb_req] <= bus.wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sb_err <= 1'b0;
        else if (en && !flush && |unf)
            sb_err <= 1'b1;
    end
endmodule

// File: tb/tb_pst_id_scoreboard_rf.sv
// tb_pst_id_scoreboard_rf: scoreboard bench for the scoreboarded register file
module tb_pst_id_scoreboard_rf;
    import pst_id_scoreboard_rf_pkg::*;

    localparam int SEL_RD0 = 0, SEL_RD1 = 1, SEL_STALL = 2, SEL_BUSY = 3, SEL_ERR = 4, SEL_DBG = 5;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        flush;
    logic        busy;
    logic        sb_err;
    logic [4:0]  dbg_req;
    logic [31:0] dbg_data;
    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        q[$];

    pst_id_scoreboard_rf_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus ();

    pst_id_scoreboard_rf #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .MAX_PEND(3)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .flush    (flush),
        .bus      (bus),
        .busy     (busy),
        .sb_err   (sb_err),
        .dbg_req  (dbg_req),
        .dbg_data (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_RD0:   return bus.rd_data[31:0];
            SEL_RD1:   return bus.rd_data[63:32];
            SEL_STALL: return {31'd0, bus.stall};
            SEL_BUSY:  return {31'd0, busy};
            SEL_ERR:   return {31'd0, sb_err};
            default:   return dbg_data;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] e);
        exp_t x;
        x.tag = tag;
        x.sel = sel;
        x.exp = e;
        q.push_back(x);
    endtask

    task automatic drain();
        exp_t x;
        while (q.size() > 0) begin
            x = q.pop_front();
            chk(x.tag, observe(x.sel), x.exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 1'b1;
        flush = 1'b0;
        bus.issue_valid = 1'b0;
        bus.issue_we = 1'b0;
        bus.issue_req_w = '0;
        bus.rd_need = '0;
        bus.rd_req = '0;
        bus.wb_we = 1'b0;
        bus.wb_req = '0;
        bus.wb_data = '0;
    endtask

    task automatic iss(input logic [4:0] r);
        bus.issue_valid = 1'b1;
        bus.issue_we = 1'b1;
        bus.issue_req_w = r;
    endtask

    task automatic wb(input logic [4:0] r, input logic [31:0] d);
        bus.wb_we = 1'b1;
        bus.wb_req = r;
        bus.wb_data = d;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] need);
        bus.rd_req = {a1, a0};
        bus.rd_need = need;
    endtask

    initial begin
        idle();
        dbg_req = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        idle(); rd(5, 6, 2'b11);
        push("rst_rd0", SEL_RD0, 0); push("rst_rd1", SEL_RD1, 0); push("rst_stall", SEL_STALL, 0);
        push("rst_busy", SEL_BUSY, 0); push("rst_err", SEL_ERR, 0); push("rst_dbg", SEL_DBG, 0);
        cyc();

        idle(); iss(5); push("r5_iss_stall", SEL_STALL, 0); cyc();
        idle(); rd(5, 6, 2'b11); wb(5, 32'hDEADBEEF);
        push("r5_busy", SEL_BUSY, 1); push("r5_bypass", SEL_RD0, 32'hDEADBEEF); push("r5_rd1", SEL_RD1, 0);
        cyc();
        idle(); dbg_req = 5;
        push("r5_dbg", SEL_DBG, 32'hDEADBEEF); push("r5_idle", SEL_BUSY, 0); push("r5_err", SEL_ERR, 0);
        cyc();

        idle(); iss(8); push("r8_iss", SEL_STALL, 0); cyc();
        for (int k = 0; k < 2; k++) begin
            idle(); bus.issue_valid = 1'b1; rd(8, 0, 2'b01);
            push("r8_raw_stall", SEL_STALL, 1); push("r8_busy", SEL_BUSY, 1);
            cyc();
        end
        idle(); bus.issue_valid = 1'b1; rd(8, 0, 2'b01); wb(8, 32'h1234);
        push("r8_wb_stall", SEL_STALL, 0); push("r8_wb_bypass", SEL_RD0, 32'h1234);
        cyc();
        idle(); dbg_req = 8; push("r8_dbg", SEL_DBG, 32'h1234); push("r8_idle", SEL_BUSY, 0); cyc();

        for (int k = 0; k < 3; k++) begin
            idle(); iss(9); push("r9_fill", SEL_STALL, 0); cyc();
        end
        idle(); iss(9); push("r9_ovf", SEL_STALL, 1); cyc();
        idle(); wb(9, 32'h9); push("r9_busy", SEL_BUSY, 1); cyc();
        idle(); iss(9); push("r9_refill", SEL_STALL, 0); cyc();
        idle(); iss(9); push("r9_ovf_again", SEL_STALL, 1); cyc();
        for (int k = 0; k < 3; k++) begin
            idle(); wb(9, 32'h9); cyc();
        end
        idle(); push("r9_drained", SEL_BUSY, 0); push("r9_err", SEL_ERR, 0); cyc();

        idle(); iss(10); cyc();
        idle(); iss(10); wb(10, 32'hA); push("r10_net0_stall", SEL_STALL, 0); cyc();
        idle(); bus.issue_valid = 1'b1; rd(10, 0, 2'b00);
        push("r10_noneed", SEL_STALL, 0); push("r10_busy", SEL_BUSY, 1);
        cyc();
        idle(); bus.issue_valid = 1'b1; rd(10, 0, 2'b01); push("r10_need", SEL_STALL, 1); cyc();
        idle(); wb(10, 32'hA); cyc();
        idle(); push("r10_idle", SEL_BUSY, 0); push("r10_err", SEL_ERR, 0); cyc();

        idle(); en = 1'b0; wb(2, 32'h55); iss(2); push("en0_stall", SEL_STALL, 1); cyc();
        idle(); dbg_req = 2; bus.issue_valid = 1'b1; rd(2, 0, 2'b01);
        push("en0_dbg", SEL_DBG, 0); push("en0_cnt", SEL_STALL, 0);
        push("en0_busy", SEL_BUSY, 0); push("en0_err", SEL_ERR, 0);
        cyc();
        idle(); wb(0, 32'hFF); rd(0, 0, 2'b11); push("r0_nobypass", SEL_RD0, 0); cyc();
        idle(); dbg_req = 0; push("r0_dbg", SEL_DBG, 0); push("r0_err", SEL_ERR, 0); cyc();

        idle(); iss(3); cyc();
        idle(); iss(4); cyc();
        idle(); flush = 1'b1; push("fl_busy_pre", SEL_BUSY, 1); cyc();
        idle(); push("fl_busy_post", SEL_BUSY, 0); cyc();
        idle(); wb(3, 32'h7); cyc();
        idle(); dbg_req = 3; push("fl_dbg", SEL_DBG, 7); push("fl_err", SEL_ERR, 1); cyc();
        repeat (2) begin
            idle(); cyc();
        end
        idle(); push("fl_err_sticky", SEL_ERR, 1); cyc();

        idle(); iss(11); cyc();
        idle(); push("mid_busy", SEL_BUSY, 1);
        @(negedge clk);
        drain();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_err", {31'd0, sb_err}, 0);
        chk("mid_rst_dbg", dbg_data, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
